i2s_tdm_receiver: RTL and testbench
===================================

I2S_TDM_RECEIVER -- requirements
Module: i2s_tdm_receiver

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 24: captured bits per channel (8..32).
REQ-002 SHALL have parameter SLOT_WIDTH, default 32: bit clocks per slot (≥ SAMPLE_WIDTH).
REQ-003 SHALL have parameter CHANNELS, default 2: slots per frame (2..8; >2 is TDM).
REQ-004 SHALL have parameter MODE, default 0: 0 = I2S (one-bit delay), 1 = left-justified (no delay).
REQ-005 SHALL have one clock and an asynchronous, active-low reset; the clock port is i_clock.
REQ-006 Ports SHALL be as follows; all codec inputs are asynchronous to i_clock:
- i_clock  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_enable  in  1  receiver enable
- i_codec_bit_clock  in  1  serial bit clock
- i_codec_lr_clock  in  1  frame/LR clock
- i_codec_adc_data  in  1  serial data
- o_data  out  CHANNELS*SAMPLE_WIDTH  packed frame; channel k in bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH]
- o_data_valid  out  1  frame available
- i_data_ready  in  1  consumer accept
- o_overflow  out  1  one-cycle pulse: completed frame dropped
- o_frame_error  out  1  one-cycle pulse: short frame detected

Function
REQ-007 Codec inputs SHALL pass through a 2-flop synchroniser; edges SHALL be detected against a third delayed flop, giving registered one-cycle rising and falling flags.
REQ-008 A frame SHALL start on the LR falling flag while i_enable=1; channel 0 is the first slot after frame start.
REQ-009 Data SHALL be sampled on bit-clock rising flags.
- MODE 0: the first rising flag after frame start is skipped; the next one is bit 0.
- MODE 1: the first rising flag after frame start is bit 0.
REQ-010 In each slot, the first SAMPLE_WIDTH bits SHALL be shifted MSB-first into that channel's register; the remaining SLOT_WIDTH−SAMPLE_WIDTH bits are ignored.
REQ-011 The FSM SHALL have states IDLE, ALIGN, SHIFT, PAD, WAIT_FRAME:
- IDLE→ALIGN (MODE 0) or →SHIFT (MODE 1) on the LR falling flag with i_enable=1.
- ALIGN→SHIFT on a rising flag.
- SHIFT→PAD after SAMPLE_WIDTH bits.
- PAD→SHIFT at the slot boundary, or →WAIT_FRAME after the last slot.
- WAIT_FRAME→ALIGN/SHIFT on the next LR falling flag.
REQ-012 Slot and bit counters SHALL wrap to 0 at each slot/frame boundary; counter widths SHALL be sized by $clog2 of the parameters.
REQ-013 On the cycle the last bit of channel CHANNELS−1 is shifted (cycle N), the completed frame SHALL load into o_data with o_data_valid=1 at N+1.
REQ-014 o_data and o_data_valid SHALL hold until a cycle with o_data_valid=1 and i_data_ready=1; o_data_valid then clears, unless a load occurs in that same cycle, in which case new data loads and valid stays 1.
REQ-015 If a frame completes while o_data_valid=1 and i_data_ready=0, the new frame SHALL be discarded, o_data is kept, and o_overflow pulses for one cycle.
REQ-016 An LR falling flag seen in ALIGN, SHIFT or PAD SHALL pulse o_frame_error for one cycle, discard the partial frame, and restart the frame at that edge.
REQ-017 Extra bit clocks in WAIT_FRAME SHALL be ignored without error.
REQ-018 Deasserting i_enable SHALL force IDLE within one cycle and discard any partial frame; the output register and handshake are unaffected.
REQ-019 LR rising edges SHALL NOT affect the FSM.

Reset
REQ-020 Asserting i_reset_n=0 SHALL immediately set the state to IDLE, all counters, shift registers, synchroniser flops and o_data to 0, and o_data_valid, o_overflow and o_frame_error to 0.
REQ-021 Reset SHALL be honoured mid-frame and mid-handshake; the first frame after release starts at the next LR falling flag.

Structure
REQ-022 Package i2s_pkg SHALL hold the MODE constants (MODE_I2S=0, MODE_LJ=1) and the FSM state typedef.
REQ-023 Sub-module i2s_edge_sync (2-flop sync plus delay flop plus rising/falling flags) SHALL be instantiated once for bit clock and once for LR clock; data SHALL use its synchronised output only.

Verification
REQ-024 Defaults, MODE 0: left 0xA5A5A5, right 0x123456 → one valid with o_data = 0x123456_A5A5A5, no error pulses.
REQ-025 CHANNELS=4, SLOT_WIDTH=32, SAMPLE_WIDTH=16, MODE 1: slots 0x1111, 0x2222, 0x3333, 0x4444 → o_data = 0x4444_3333_2222_1111.
REQ-026 i_data_ready held 0 across two frames → first frame is retained, one o_overflow pulse; ready=1 → valid clears.
REQ-027 LR falls after 10 bits of the left slot → one o_frame_error pulse, and the following complete frame is captured correctly.
REQ-028 Reset asserted mid-right-slot → all outputs 0 immediately; the next full frame after release is received correctly.
REQ-029 i_enable dropped mid-frame and raised → no valid for the partial frame; the next frame is correct.

Source files
------------

// File: rtl/i2s_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : i2s_pkg
// Description : Shared constants and types for the I2S/TDM receiver.
//               MODE_I2S / MODE_LJ select the data-to-LR alignment;
//               rx_state_t is the framing FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    localparam int MODE_I2S = 0;    // data MSB one bit clock after LR falls
    localparam int MODE_LJ  = 1;    // data MSB on the first bit clock after LR falls

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ALIGN      = 3'd1,
        SHIFT      = 3'd2,
        PAD        = 3'd3,
        WAIT_FRAME = 3'd4
    } rx_state_t;

endpackage : i2s_pkg
`default_nettype wire

// File: rtl/i2s_edge_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : i2s_edge_sync
// Description : Brings one asynchronous codec clock into the i_clock domain
//               through two flops, delays it by a third flop and produces
//               registered one-cycle rising / falling flags.
// Ports       : i_clock    - system clock
//               i_reset_n  - asynchronous active-low reset
//               i_async    - asynchronous input
//               o_rise     - one-cycle pulse after a 0->1 transition
//               o_fall     - one-cycle pulse after a 1->0 transition
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_edge_sync (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_delay;
    logic r_rise;
    logic r_fall;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_delay <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_meta  <= i_async;
            r_sync  <= r_meta;
            r_delay <= r_sync;
            r_rise  <= r_sync & ~r_delay;
            r_fall  <= ~r_sync & r_delay;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule : i2s_edge_sync
`default_nettype wire

// File: rtl/i2s_tdm_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : i2s_tdm_receiver
// Description : I2S / left-justified / TDM serial audio receiver. Oversamples
//               the codec bit clock, LR clock and data with i_clock, deframes
//               CHANNELS slots per LR period and presents each complete frame
//               on a valid/ready output register.
// Ports       : i_clock, i_reset_n        - clock, async active-low reset
//               i_enable                  - receiver enable
//               i_codec_bit_clock         - serial bit clock (async)
//               i_codec_lr_clock          - frame / LR clock (async)
//               i_codec_adc_data          - serial data (async)
//               o_data                    - packed frame, channel k at
//                                           [k*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//               o_data_valid/i_data_ready - output handshake
//               o_overflow                - pulse: completed frame dropped
//               o_frame_error             - pulse: short frame detected
// Note        : in MODE_I2S the last bit of a frame arrives after the next
//               LR fall, so SAMPLE_WIDTH must be below SLOT_WIDTH there.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_tdm_receiver
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 32,
    parameter int CHANNELS     = 2,
    parameter int MODE         = 0
) (
    input  logic                             i_clock,
    input  logic                             i_reset_n,
    input  logic                             i_enable,
    input  logic                             i_codec_bit_clock,
    input  logic                             i_codec_lr_clock,
    input  logic                             i_codec_adc_data,
    output logic [CHANNELS*SAMPLE_WIDTH-1:0] o_data,
    output logic                             o_data_valid,
    input  logic                             i_data_ready,
    output logic                             o_overflow,
    output logic                             o_frame_error
);

    localparam int BIT_W  = $clog2(SLOT_WIDTH);
    localparam int SLOT_W = $clog2(CHANNELS);
    localparam int FRAME_W = CHANNELS * SAMPLE_WIDTH;

    localparam logic [BIT_W-1:0]  c_last_sample_bit = BIT_W'(SAMPLE_WIDTH - 1);
    localparam logic [BIT_W-1:0]  c_last_slot_bit   = BIT_W'(SLOT_WIDTH - 1);
    localparam logic [SLOT_W-1:0] c_last_slot       = SLOT_W'(CHANNELS - 1);
    localparam bit                c_has_pad         = (SLOT_WIDTH > SAMPLE_WIDTH);
    localparam rx_state_t         c_start_state     = (MODE == MODE_I2S) ? ALIGN : SHIFT;

    // ------------------------------------------------------------------------
    // Codec input conditioning
    // ------------------------------------------------------------------------
    logic w_bclk_rise;
    logic w_bclk_fall;
    logic w_lr_rise;
    logic w_lr_fall;
    logic r_data_meta;
    logic r_data_sync;

    i2s_edge_sync u_bclk_sync (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_async   (i_codec_bit_clock),
        .o_rise    (w_bclk_rise),
        .o_fall    (w_bclk_fall)
    );

    i2s_edge_sync u_lr_sync (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_async   (i_codec_lr_clock),
        .o_rise    (w_lr_rise),
        .o_fall    (w_lr_fall)
    );

    // Only rising bit-clock and falling LR edges carry meaning here.
    logic w_unused_edges;
    assign w_unused_edges = w_bclk_fall ^ w_lr_rise;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_data_meta <= 1'b0;
            r_data_sync <= 1'b0;
        end else begin
            r_data_meta <= i_codec_adc_data;
            r_data_sync <= r_data_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Framing FSM and counters
    // ------------------------------------------------------------------------
    rx_state_t           r_state;
    rx_state_t           w_state_next;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [BIT_W-1:0]    w_bit_next;
    logic [SLOT_W-1:0]   r_slot_cnt;
    logic [SLOT_W-1:0]   w_slot_next;
    logic [SAMPLE_WIDTH-1:0] r_shift;
    logic [SAMPLE_WIDTH-1:0] w_sample_next;
    logic [FRAME_W-1:0]  r_frame;
    logic [FRAME_W-1:0]  w_frame_full;
    logic                w_shift_en;
    logic                w_sample_done;
    logic                w_frame_done;
    logic                w_frame_err;

    always_comb begin
        w_state_next  = r_state;
        w_bit_next    = r_bit_cnt;
        w_slot_next   = r_slot_cnt;
        w_shift_en    = 1'b0;
        w_sample_done = 1'b0;
        w_frame_done  = 1'b0;
        w_frame_err   = 1'b0;

        if (!i_enable) begin
            w_state_next = IDLE;
            w_bit_next   = '0;
            w_slot_next  = '0;
        end else if (w_lr_fall) begin
            // Any LR fall (re)starts a frame; mid-frame it also flags the
            // frame that was in progress as short.
            w_frame_err  = (r_state == ALIGN) || (r_state == SHIFT) || (r_state == PAD);
            w_state_next = c_start_state;
            w_bit_next   = '0;
            w_slot_next  = '0;
        end else begin
            case (r_state)
                IDLE, WAIT_FRAME: begin
                    w_state_next = r_state;
                end
                ALIGN: begin
                    if (w_bclk_rise) begin
                        w_state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_bclk_rise) begin
                        w_shift_en = 1'b1;
                        w_bit_next = r_bit_cnt + BIT_W'(1);
                        if (r_bit_cnt == c_last_sample_bit) begin
                            w_sample_done = 1'b1;
                            if (r_slot_cnt == c_last_slot) begin
                                w_frame_done = 1'b1;
                            end
                            if (c_has_pad) begin
                                w_state_next = PAD;
                            end else if (r_slot_cnt == c_last_slot) begin
                                w_state_next = WAIT_FRAME;
                                w_bit_next   = '0;
                                w_slot_next  = '0;
                            end else begin
                                w_bit_next  = '0;
                                w_slot_next = r_slot_cnt + SLOT_W'(1);
                            end
                        end
                    end
                end
                PAD: begin
                    // The final slot's padding runs into the next LR fall,
                    // so the frame is closed as soon as its data is in.
                    if (r_slot_cnt == c_last_slot) begin
                        w_state_next = WAIT_FRAME;
                        w_bit_next   = '0;
                        w_slot_next  = '0;
                    end else if (w_bclk_rise) begin
                        if (r_bit_cnt == c_last_slot_bit) begin
                            w_state_next = SHIFT;
                            w_bit_next   = '0;
                            w_slot_next  = r_slot_cnt + SLOT_W'(1);
                        end else begin
                            w_bit_next = r_bit_cnt + BIT_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_bit_next   = '0;
                    w_slot_next  = '0;
                end
            endcase
        end
    end

    // Current sample with the new bit appended, and the frame with that
    // sample dropped into the current slot's lane.
    always_comb begin
        w_sample_next = {r_shift[SAMPLE_WIDTH-2:0], r_data_sync};
        w_frame_full  = r_frame;
        w_frame_full[int'(r_slot_cnt)*SAMPLE_WIDTH +: SAMPLE_WIDTH] = w_sample_next;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_slot_cnt <= '0;
            r_shift    <= '0;
            r_frame    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_bit_cnt  <= w_bit_next;
            r_slot_cnt <= w_slot_next;
            if (w_shift_en) begin
                r_shift <= w_sample_next;
            end
            if (w_sample_done) begin
                r_frame <= w_frame_full;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output register and handshake
    // ------------------------------------------------------------------------
    logic [FRAME_W-1:0] r_data;
    logic               r_valid;
    logic               r_overflow;
    logic               r_frame_error;
    logic               w_blocked;

    assign w_blocked = r_valid & ~i_data_ready;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_overflow    <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_overflow    <= w_frame_done & w_blocked;
            r_frame_error <= w_frame_err;
            if (w_frame_done && !w_blocked) begin
                r_data  <= w_frame_full;
                r_valid <= 1'b1;
            end else if (r_valid && i_data_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data        = r_data;
    assign o_data_valid  = r_valid;
    assign o_overflow    = r_overflow;
    assign o_frame_error = r_frame_error | (w_unused_edges & 1'b0);

endmodule : i2s_tdm_receiver
`default_nettype wire

// File: tb/tb_i2s_tdm_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_i2s_tdm_receiver
// Description : Directed self-checking bench. DUT A uses the default stereo
//               I2S configuration; DUT B is 4-slot TDM, 16-of-32 bits,
//               left-justified. The bench drives one codec stream and routes
//               it to whichever DUT is active.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tdm_receiver;

    localparam int BIT_HALF = 40;   // bit clock half period, ns (4 system clocks)

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic enable;
    logic ready;
    logic bclk;
    logic lrclk;
    logic sdata;
    int   active;

    int n_total = 0;
    int n_bad   = 0;

    // Stream routing: the idle DUT sees a quiet bus with LR parked high.
    logic a_bclk, a_lr, a_data, b_bclk, b_lr, b_data;
    assign a_bclk = (active == 0) ? bclk  : 1'b0;
    assign a_lr   = (active == 0) ? lrclk : 1'b1;
    assign a_data = (active == 0) ? sdata : 1'b0;
    assign b_bclk = (active == 1) ? bclk  : 1'b0;
    assign b_lr   = (active == 1) ? lrclk : 1'b1;
    assign b_data = (active == 1) ? sdata : 1'b0;

    logic [47:0] a_odata;
    logic        a_valid, a_ovf, a_ferr;
    logic [63:0] b_odata;
    logic        b_valid, b_ovf, b_ferr;

    i2s_tdm_receiver u_dut_a (
        .i_clock           (clk),
        .i_reset_n         (rst_n),
        .i_enable          (enable),
        .i_codec_bit_clock (a_bclk),
        .i_codec_lr_clock  (a_lr),
        .i_codec_adc_data  (a_data),
        .o_data            (a_odata),
        .o_data_valid      (a_valid),
        .i_data_ready      (ready),
        .o_overflow        (a_ovf),
        .o_frame_error     (a_ferr)
    );

    i2s_tdm_receiver #(
        .SAMPLE_WIDTH (16),
        .SLOT_WIDTH   (32),
        .CHANNELS     (4),
        .MODE         (1)
    ) u_dut_b (
        .i_clock           (clk),
        .i_reset_n         (rst_n),
        .i_enable          (enable),
        .i_codec_bit_clock (b_bclk),
        .i_codec_lr_clock  (b_lr),
        .i_codec_adc_data  (b_data),
        .o_data            (b_odata),
        .o_data_valid      (b_valid),
        .i_data_ready      (ready),
        .o_overflow        (b_ovf),
        .o_frame_error     (b_ferr)
    );

    // Pulse monitors: count cycles each pulse output is high.
    int a_ovf_cnt = 0, a_err_cnt = 0, b_ovf_cnt = 0, b_err_cnt = 0;
    always @(posedge clk) begin
        if (a_ovf)  a_ovf_cnt <= a_ovf_cnt + 1;
        if (a_ferr) a_err_cnt <= a_err_cnt + 1;
        if (b_ovf)  b_ovf_cnt <= b_ovf_cnt + 1;
        if (b_ferr) b_err_cnt <= b_err_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic lr, input logic d);
        lrclk = lr;
        sdata = d;
        bclk  = 1'b0;
        #(BIT_HALF);
        bclk = 1'b1;
        #(BIT_HALF);
        bclk = 1'b0;
    endtask

    // cfg 0: 2 x 24/32 I2S; cfg 1: 4 x 16/32 left-justified.
    // LR is low for the first half of the slots. A truncated frame is
    // followed by one LR-high bit so that the next frame has an LR fall.
    task automatic send_frame(input int cfg, input logic [31:0] s0, input logic [31:0] s1,
                              input logic [31:0] s2, input logic [31:0] s3, input int nbits);
        logic [31:0] smp [4];
        int ch, sw, slw, total, dp;
        logic d, lr;
        smp[0] = s0; smp[1] = s1; smp[2] = s2; smp[3] = s3;
        if (cfg == 0) begin ch = 2; sw = 24; slw = 32; end
        else          begin ch = 4; sw = 16; slw = 32; end
        total = ch * slw;
        for (int p = 0; p < nbits; p++) begin
            lr = (p >= total / 2);
            dp = (cfg == 0) ? p - 1 : p;
            d  = 1'b0;
            if (dp >= 0 && (dp % slw) < sw) begin
                d = smp[dp / slw][sw - 1 - (dp % slw)];
            end
            drive_bit(lr, d);
        end
        if (nbits < total) drive_bit(1'b1, 1'b0);
    endtask

    task automatic pulse_ready();
        @(negedge clk) ready = 1'b1;
        @(negedge clk) ready = 1'b0;
    endtask

    int err0;

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        ready  = 1'b0;
        bclk   = 1'b0;
        lrclk  = 1'b1;
        sdata  = 1'b0;
        active = 0;
        repeat (4) @(negedge clk);
        check_eq("reset_data",  {16'h0, a_odata}, 64'h0);
        check_eq("reset_valid", {63'h0, a_valid}, 64'h0);
        check_eq("reset_ovf",   {63'h0, a_ovf},   64'h0);
        check_eq("reset_ferr",  {63'h0, a_ferr},  64'h0);
        check_eq("reset_b_valid", {63'h0, b_valid}, 64'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Basic stereo I2S frame
        send_frame(0, 32'hA5A5A5, 32'h123456, 0, 0, 64);
        repeat (4) @(negedge clk);
        check_eq("i2s_valid", {63'h0, a_valid}, 64'h1);
        check_eq("i2s_data",  {16'h0, a_odata}, 64'h123456_A5A5A5);
        check_eq("i2s_no_err", 64'(a_err_cnt), 64'd0);
        check_eq("i2s_no_ovf", 64'(a_ovf_cnt), 64'd0);

        // Second frame while blocked: dropped, one overflow pulse
        send_frame(0, 32'h111111, 32'h222222, 0, 0, 64);
        repeat (4) @(negedge clk);
        check_eq("ovf_data_kept", {16'h0, a_odata}, 64'h123456_A5A5A5);
        check_eq("ovf_valid",     {63'h0, a_valid}, 64'h1);
        check_eq("ovf_pulse",     64'(a_ovf_cnt),   64'd1);
        pulse_ready();
        check_eq("ready_clears", {63'h0, a_valid}, 64'h0);

        // Short frame (10 data bits of the left slot) then a full frame
        send_frame(0, 32'hFFFFFF, 32'hFFFFFF, 0, 0, 11);
        send_frame(0, 32'h0F0F0F, 32'hF0F0F0, 0, 0, 64);
        repeat (4) @(negedge clk);
        check_eq("short_err_pulse", 64'(a_err_cnt),   64'd1);
        check_eq("short_valid",     {63'h0, a_valid}, 64'h1);
        check_eq("short_next_data", {16'h0, a_odata}, 64'hF0F0F0_0F0F0F);

        // Reset in the middle of the right slot, valid still pending
        send_frame(0, 32'h777777, 32'h888888, 0, 0, 44);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_data",  {16'h0, a_odata}, 64'h0);
        check_eq("midrst_valid", {63'h0, a_valid}, 64'h0);
        check_eq("midrst_ovf",   {63'h0, a_ovf},   64'h0);
        check_eq("midrst_ferr",  {63'h0, a_ferr},  64'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        err0 = a_err_cnt;
        send_frame(0, 32'h654321, 32'hABCDEF, 0, 0, 64);
        repeat (4) @(negedge clk);
        check_eq("postrst_valid", {63'h0, a_valid}, 64'h1);
        check_eq("postrst_data",  {16'h0, a_odata}, 64'hABCDEF_654321);
        check_eq("postrst_no_err", 64'(a_err_cnt - err0), 64'd0);
        pulse_ready();

        // Enable dropped mid-frame: partial frame discarded, next one correct
        fork
            send_frame(0, 32'h5A5A5A, 32'h3C3C3C, 0, 0, 64);
            begin
                #(20 * 2 * BIT_HALF);
                enable = 1'b0;
                #200;
                enable = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        check_eq("en_drop_no_valid", {63'h0, a_valid}, 64'h0);
        send_frame(0, 32'hC0FFEE, 32'h00BEEF, 0, 0, 64);
        repeat (4) @(negedge clk);
        check_eq("en_next_valid",  {63'h0, a_valid}, 64'h1);
        check_eq("en_next_data",   {16'h0, a_odata}, 64'h00BEEF_C0FFEE);
        check_eq("en_no_err",      64'(a_err_cnt - err0), 64'd0);
        pulse_ready();

        // TDM left-justified on DUT B
        active = 1;
        repeat (4) @(negedge clk);
        send_frame(1, 32'h1111, 32'h2222, 32'h3333, 32'h4444, 128);
        repeat (4) @(negedge clk);
        check_eq("tdm_valid", {63'h0, b_valid}, 64'h1);
        check_eq("tdm_data",  b_odata,          64'h4444_3333_2222_1111);
        check_eq("tdm_no_err", 64'(b_err_cnt),  64'd0);
        check_eq("tdm_no_ovf", 64'(b_ovf_cnt),  64'd0);
        pulse_ready();
        check_eq("tdm_ready_clears", {63'h0, b_valid}, 64'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_i2s_tdm_receiver
`default_nettype wire
